// File: rtl/instruction_pkg.sv
// Shared encodings for the RV32I memory stage: memory-op codes, FSM states and
// small decode helpers used by both the stage and its alignment unit.
package instruction_pkg;

    typedef enum logic [3:0] {
        MINST_LB   = 4'b0000,
        MINST_LH   = 4'b0001,
        MINST_LW   = 4'b0010,
        MINST_LBU  = 4'b0100,
        MINST_LHU  = 4'b0101,
        MINST_SB   = 4'b1000,
        MINST_SH   = 4'b1001,
        MINST_SW   = 4'b1010,
        MINST_NONE = 4'b1100
    } minst_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic is_mem_op(input logic [3:0] minst);
        case (minst)
            MINST_LB, MINST_LH, MINST_LW, MINST_LBU, MINST_LHU,
            MINST_SB, MINST_SH, MINST_SW: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_ready;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_wstrb;
    logic [31:0]       dmem_wdata;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store strobe/data replication and load
// extraction with sign or zero extension.
module mem_align
    import instruction_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
        return 32'(v);
    endfunction

    logic [31:0] shifted;

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (st_size)
            SZ_B: begin
                st_wstrb = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // The addressed byte/halfword is moved down to lane 0 before extension.
    assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_funct3)
            3'b000:  ld_data = sext8(shifted[7:0]);
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b001:  ld_data = sext16(shifted[15:0]);
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on the data-memory bus, stalls
// upstream while a transaction is outstanding, and produces the writeback record.
module mem_stage
    import instruction_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter bit STORE_ACK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  minst_i,
    input  logic [31:0] result_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_v_i,
    output logic        hazard_m,
    mem_stage_if.master dmem,
    output logic        wb_v,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_o
);

    mem_state_e  state;
    mem_state_e  state_nxt;

    logic        cmd_mem;
    logic        cmd_mis;
    logic        issue;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    logic [2:0]  ld_funct3_p1;
    logic [1:0]  ld_lo_p1;
    logic [4:0]  rd_p1;
    logic        rd_v_p1;
    logic        store_p1;

    assign cmd_mem = is_mem_op(minst_i);
    assign cmd_mis = is_misaligned(minst_i[1:0], result_i[1:0]);
    assign issue   = (state == IDLE) && cmd_mem && !cmd_mis;

    mem_align u_align (
        .st_size    (minst_i[1:0]),
        .st_addr_lo (result_i[1:0]),
        .st_data    (wdata_i),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .ld_funct3  (ld_funct3_p1),
        .ld_addr_lo (ld_lo_p1),
        .ld_rdata   (dmem.dmem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ:  if (dmem.dmem_ready) state_nxt = (!store_p1 || STORE_ACK) ? RESP : IDLE;
            RESP: if (dmem.dmem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: command captured at acceptance for use when the response returns
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_mem) begin
            ld_funct3_p1 <= minst_i[2:0];
            ld_lo_p1     <= result_i[1:0];
            rd_p1        <= rd_i;
            rd_v_p1      <= rd_v_i;
            store_p1     <= minst_i[3];
        end
    end

    // p1 -> bus/writeback: registered request and writeback outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hazard_m        <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wstrb <= 4'b0000;
            dmem.dmem_wdata <= 32'h0;
            wb_v            <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= 32'h0;
            misalign_o      <= 1'b0;
        end else begin
            hazard_m   <= (state_nxt != IDLE);
            wb_v       <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_mem) begin
                        if (cmd_mis) begin
                            misalign_o <= 1'b1;
                        end else begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= minst_i[3];
                            dmem.dmem_addr  <= {result_i[ADDR_W-1:2], 2'b00};
                            dmem.dmem_wstrb <= st_wstrb;
                            dmem.dmem_wdata <= st_wdata;
                        end
                    end else begin
                        wb_v    <= rd_v_i;
                        wb_rd   <= rd_i;
                        wb_data <= result_i;
                    end
                end
                REQ: begin
                    if (dmem.dmem_ready) dmem.dmem_req <= 1'b0;
                end
                RESP: begin
                    // A store waiting for its write ack retires without writeback.
                    if (dmem.dmem_rvalid && !store_p1) begin
                        wb_v    <= rd_v_p1;
                        wb_rd   <= rd_p1;
                        wb_data <= ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, multi-cycle/reset sequences and a
// randomized run against a byte-addressed reference memory.
module tb_mem_stage;
    import instruction_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  minst_i;
    logic [31:0] result_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_i;
    logic        rd_v_i;
    logic        hazard_m;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_if #(.ADDR_W(32)) bus ();

    mem_stage #(.ADDR_W(32), .STORE_ACK(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .minst_i    (minst_i),
        .result_i   (result_i),
        .wdata_i    (wdata_i),
        .rd_i       (rd_i),
        .rd_v_i     (rd_v_i),
        .hazard_m   (hazard_m),
        .dmem       (bus),
        .wb_v       (wb_v),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign_o (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: automatic (latency-driven) or manual drive
    bit          auto_en;
    int          ready_lat, rvalid_lat;
    logic        r_ready, r_rvalid, m_ready, m_rvalid;
    logic [31:0] r_rdata, m_rdata;
    logic [31:0] resp_mem [logic [31:0]];
    logic [7:0]  ref_mem  [logic [31:0]];

    assign bus.dmem_ready  = auto_en ? r_ready  : m_ready;
    assign bus.dmem_rvalid = auto_en ? r_rvalid : m_rvalid;
    assign bus.dmem_rdata  = auto_en ? r_rdata  : m_rdata;

    initial begin
        int phase;
        int cnt;
        logic [31:0] a;
        logic [31:0] w;
        phase = 0; cnt = 0; a = 0;
        r_ready = 0; r_rvalid = 0; r_rdata = 0;
        forever begin
            @(negedge clk);
            r_ready = 0; r_rvalid = 0;
            if (!reset || !auto_en) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (bus.dmem_req) begin
                    if (cnt >= ready_lat) begin
                        r_ready = 1; cnt = 0; a = bus.dmem_addr;
                        if (bus.dmem_we) begin
                            w = resp_mem.exists(a) ? resp_mem[a] : 32'h0;
                            for (int i = 0; i < 4; i++)
                                if (bus.dmem_wstrb[i]) w[8*i +: 8] = bus.dmem_wdata[8*i +: 8];
                            resp_mem[a] = w;
                        end else begin
                            phase = 1;
                        end
                    end else cnt++;
                end else cnt = 0;
            end else begin
                if (cnt >= rvalid_lat) begin
                    r_rvalid = 1;
                    r_rdata  = resp_mem.exists(a) ? resp_mem[a] : 32'h0;
                    phase = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        resp_mem[addr] = word;
        for (int i = 0; i < 4; i++) ref_mem[addr + 32'(i)] = word[8*i +: 8];
    endtask

    // Reference model: byte-addressed memory, plain arithmetic
    function automatic int op_size(input logic [3:0] m);
        return (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] m, input logic [31:0] addr);
        longint v = 0;
        int sz = op_size(m);
        for (int i = 0; i < sz; i++) begin
            logic [31:0] ba = addr + 32'(i);
            v += longint'(ref_mem.exists(ba) ? ref_mem[ba] : 8'h0) << (8 * i);
        end
        if (!m[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    typedef struct {
        int          samples;
        int          req_cycles;
        int          wb_cnt;
        int          mis_cnt;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          addr_stable;
    } res_t;

    task automatic sample(inout res_t r);
        if (bus.dmem_req) begin
            if (r.req_cycles == 0) begin
                r.we = bus.dmem_we; r.addr = bus.dmem_addr;
                r.wstrb = bus.dmem_wstrb; r.wdata = bus.dmem_wdata;
            end else if (bus.dmem_addr !== r.addr || bus.dmem_wstrb !== r.wstrb ||
                         bus.dmem_wdata !== r.wdata || bus.dmem_we !== r.we) begin
                r.addr_stable = 0;
            end
            r.req_cycles++;
        end
        if (wb_v) begin r.wb_cnt++; r.rd = wb_rd; r.data = wb_data; end
        if (misalign_o) r.mis_cnt++;
    endtask

    // Present one op at posedge+1, run until the stage is idle, plus one trailing cycle.
    task automatic do_op(input logic [3:0] m, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rdv, input int rl, input int vl,
                         output res_t r);
        bit done;
        r.samples = 0; r.req_cycles = 0; r.wb_cnt = 0; r.mis_cnt = 0; r.rd = 0; r.data = 0;
        r.we = 0; r.addr = 0; r.wstrb = 0; r.wdata = 0; r.addr_stable = 1;
        ready_lat = rl; rvalid_lat = vl;
        minst_i = m; result_i = addr; wdata_i = wd; rd_i = rd; rd_v_i = rdv;
        @(posedge clk); #1;
        minst_i = MINST_NONE; rd_v_i = 1'b0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            r.samples++;
            sample(r);
            if (!hazard_m) done = 1;
            else begin @(posedge clk); #1; end
        end
        chk("op_completes", 32'(done), 32'd1);
        @(posedge clk); #1;
        sample(r);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  minst;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rdv;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t        tv [16];
    res_t        r;
    logic [3:0]  ops [10];

    initial begin
        tv[0]  = '{"lb_0x103",   MINST_LB,   32'h103, 32'h0,        5'd1,  1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        tv[1]  = '{"lbu_0x103",  MINST_LBU,  32'h103, 32'h0,        5'd2,  1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000080, 1'b0};
        tv[2]  = '{"lh_0x102",   MINST_LH,   32'h102, 32'h0,        5'd3,  1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFF8012, 1'b0};
        tv[3]  = '{"lw_0x100",   MINST_LW,   32'h100, 32'h0,        5'd5,  1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h80123456, 1'b0};
        tv[4]  = '{"sw_0x100",   MINST_SW,   32'h100, 32'hDEADBEEF, 5'd6,  1'b1, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tv[5]  = '{"sb_0x103",   MINST_SB,   32'h103, 32'hFFFF00A5, 5'd7,  1'b1, 1'b1, 1'b1, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        tv[6]  = '{"sh_0x102",   MINST_SH,   32'h102, 32'hABCD1234, 5'd8,  1'b1, 1'b1, 1'b1, 4'hC, 32'h12341234, 1'b0, 32'h0,        1'b0};
        tv[7]  = '{"lw_mis",     MINST_LW,   32'h102, 32'h0,        5'd4,  1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
        tv[8]  = '{"add_rd3",    MINST_NONE, 32'h55,  32'h0,        5'd3,  1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000055, 1'b0};
        tv[9]  = '{"lhu_0x102",  MINST_LHU,  32'h102, 32'h0,        5'd9,  1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00001234, 1'b0};
        tv[10] = '{"lb_0x100",   MINST_LB,   32'h100, 32'h0,        5'd10, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFFFFEF, 1'b0};
        tv[11] = '{"lh_mis",     MINST_LH,   32'h101, 32'h0,        5'd11, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
        tv[12] = '{"lw_nowb",    MINST_LW,   32'h100, 32'h0,        5'd12, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
        tv[13] = '{"lh_0x100",   MINST_LH,   32'h100, 32'h0,        5'd13, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0};
        tv[14] = '{"sb_0x101",   MINST_SB,   32'h101, 32'h00000077, 5'd14, 1'b1, 1'b1, 1'b1, 4'h2, 32'h77777777, 1'b0, 32'h0,        1'b0};
        tv[15] = '{"add_nowb",   MINST_NONE, 32'h99,  32'h0,        5'd15, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
        ops = '{MINST_LB, MINST_LH, MINST_LW, MINST_LBU, MINST_LHU,
                MINST_SB, MINST_SH, MINST_SW, MINST_NONE, MINST_NONE};

        auto_en = 1; ready_lat = 0; rvalid_lat = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 32'h0;
        minst_i = MINST_NONE; result_i = 0; wdata_i = 0; rd_i = 0; rd_v_i = 0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hazard", 32'(hazard_m), 0);
        chk("rst_req",    32'(bus.dmem_req), 0);
        chk("rst_we",     32'(bus.dmem_we), 0);
        chk("rst_addr",   bus.dmem_addr, 0);
        chk("rst_wstrb",  32'(bus.dmem_wstrb), 0);
        chk("rst_wdata",  bus.dmem_wdata, 0);
        chk("rst_wb_v",   32'(wb_v), 0);
        chk("rst_wb_rd",  32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mis",    32'(misalign_o), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed vector table, zero-latency memory
        preload(32'h100, 32'h80123456);
        foreach (tv[i]) begin
            do_op(tv[i].minst, tv[i].addr, tv[i].wd, tv[i].rd, tv[i].rdv, 0, 0, r);
            chk({tv[i].name, "_req"}, 32'(r.req_cycles), tv[i].exp_req ? 32'd1 : 32'd0);
            chk({tv[i].name, "_cycles"}, 32'(r.samples),
                !tv[i].exp_req ? 32'd1 : (tv[i].exp_we ? 32'd2 : 32'd3));
            if (tv[i].exp_req) begin
                chk({tv[i].name, "_we"},   32'(r.we), 32'(tv[i].exp_we));
                chk({tv[i].name, "_addr"}, r.addr, {tv[i].addr[31:2], 2'b00});
            end
            if (tv[i].exp_req && tv[i].exp_we) begin
                chk({tv[i].name, "_wstrb"}, 32'(r.wstrb), 32'(tv[i].exp_wstrb));
                chk({tv[i].name, "_wdata"}, r.wdata, tv[i].exp_wdata);
            end
            chk({tv[i].name, "_wb_cnt"}, 32'(r.wb_cnt), 32'(tv[i].exp_wb));
            if (tv[i].exp_wb) begin
                chk({tv[i].name, "_wb_rd"},   32'(r.rd), 32'(tv[i].rd));
                chk({tv[i].name, "_wb_data"}, r.data, tv[i].exp_data);
            end
            chk({tv[i].name, "_mis"}, 32'(r.mis_cnt), 32'(tv[i].exp_mis));
        end

        // Slow memory: ready 3 cycles late, rvalid 2 cycles after acceptance
        preload(32'h300, 32'hCAFEF00D);
        do_op(MINST_LW, 32'h300, 32'h0, 5'd17, 1'b1, 3, 2, r);
        chk("slow_cycles",  32'(r.samples), 32'd8);
        chk("slow_req",     32'(r.req_cycles), 32'd4);
        chk("slow_stable",  32'(r.addr_stable), 32'd1);
        chk("slow_wb_cnt",  32'(r.wb_cnt), 32'd1);
        chk("slow_wb_rd",   32'(r.rd), 32'd17);
        chk("slow_wb_data", r.data, 32'hCAFEF00D);

        // Manual drive: stray rvalid in REQ, reset in RESP, late rvalid
        auto_en = 0;
        minst_i = MINST_LW; result_i = 32'h300; rd_i = 5'd7; rd_v_i = 1'b1;
        @(posedge clk); #1;
        minst_i = MINST_NONE; rd_v_i = 1'b0;
        chk("man_req_a",   32'(bus.dmem_req), 1);
        chk("man_haz_a",   32'(hazard_m), 1);
        m_rvalid = 1; m_rdata = 32'h11111111;
        @(posedge clk); #1;
        chk("stray_rvalid_req", 32'(bus.dmem_req), 1);
        chk("stray_rvalid_wb",  32'(wb_v), 0);
        m_rvalid = 0; m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        chk("resp_req",  32'(bus.dmem_req), 0);
        chk("resp_haz",  32'(hazard_m), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_resp_haz", 32'(hazard_m), 0);
        chk("rst_resp_req", 32'(bus.dmem_req), 0);
        @(negedge clk); reset = 1'b1;
        m_rvalid = 1; m_rdata = 32'h22222222;
        @(posedge clk); #1;
        chk("late_rvalid_wb",  32'(wb_v), 0);
        chk("late_rvalid_haz", 32'(hazard_m), 0);
        m_rvalid = 0;
        @(posedge clk); #1;
        chk("late_rvalid_wb2", 32'(wb_v), 0);

        minst_i = MINST_SW; result_i = 32'h304; wdata_i = 32'h5A5A5A5A; rd_v_i = 1'b0;
        @(posedge clk); #1;
        minst_i = MINST_NONE;
        chk("man_req_b", 32'(bus.dmem_req), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_req_drop", 32'(bus.dmem_req), 0);
        chk("rst_req_haz",  32'(hazard_m), 0);
        @(negedge clk); reset = 1'b1;
        m_ready = 1;
        @(posedge clk); #1;
        chk("idle_ready_req", 32'(bus.dmem_req), 0);
        chk("idle_ready_haz", 32'(hazard_m), 0);
        m_ready = 0;
        auto_en = 1;
        @(posedge clk); #1;

        // Randomized ops against the byte-level reference memory
        for (int n = 0; n < 200; n++) begin
            int          k, sz, rl, vl;
            logic [3:0]  m;
            logic [31:0] addr, wd, expv, exp_wd;
            logic [3:0]  exp_st;
            logic [4:0]  rd;
            logic        rdv;
            k    = $urandom_range(0, 9);
            m    = ops[k];
            addr = 32'h200 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            rd   = 5'($urandom_range(0, 31));
            rdv  = ($urandom_range(0, 3) != 0);
            rl   = $urandom_range(0, 3);
            vl   = $urandom_range(0, 3);
            sz   = op_size(m);
            expv = (m != MINST_NONE && !m[3]) ? ref_load(m, addr) : 32'h0;
            do_op(m, addr, wd, rd, rdv, rl, vl, r);
            if (m == MINST_NONE) begin
                chk("rnd_alu_req", 32'(r.req_cycles), 0);
                chk("rnd_alu_wb",  32'(r.wb_cnt), 32'(rdv));
                if (rdv) chk("rnd_alu_data", r.data, addr);
            end else if ((addr % sz) != 0) begin
                chk("rnd_mis",     32'(r.mis_cnt), 1);
                chk("rnd_mis_req", 32'(r.req_cycles + r.wb_cnt), 0);
            end else if (m[3]) begin
                exp_st = 0; exp_wd = 0;
                for (int i = 0; i < sz; i++) begin
                    exp_st[(addr % 4) + i] = 1'b1;
                    ref_mem[addr + 32'(i)] = wd[8*i +: 8];
                end
                for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % sz) +: 8];
                chk("rnd_st_cycles", 32'(r.samples), 32'(rl + 2));
                chk("rnd_st_we",     32'(r.we), 1);
                chk("rnd_st_addr",   r.addr, addr & 32'hFFFF_FFFC);
                chk("rnd_st_wstrb",  32'(r.wstrb), 32'(exp_st));
                chk("rnd_st_wdata",  r.wdata, exp_wd);
                chk("rnd_st_wb",     32'(r.wb_cnt), 0);
            end else begin
                chk("rnd_ld_cycles", 32'(r.samples), 32'(rl + vl + 3));
                chk("rnd_ld_stable", 32'(r.addr_stable), 1);
                chk("rnd_ld_wb",     32'(r.wb_cnt), 32'(rdv));
                if (rdv) begin
                    chk("rnd_ld_rd",   32'(r.rd), 32'(rd));
                    chk("rnd_ld_data", r.data, expv);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
